control_fsm: RTL and testbench
==============================

# control_fsm

Controller state machine for the processor. It sequences the instruction-fetch unit (instruction memory, program counter, instruction register) through fetch, decode and execute. It consumes the 16-bit instruction register output and drives the fetch unit's `PC_clr`, `PC_up` and `IR_ld`. It also drives the data-memory, register-file and ALU control lines of the datapath.

## Interface
- No parameters; all widths fixed by the instruction format.
- `clk` in 1: system clock, rising-edge.
- `reset_n` in 1: asynchronous, active-low reset; forces state Init.
- `IR` in 16: instruction register output; [15:12] opcode, remaining fields per opcode.
- `PC_clr` out 1: clear program counter.
- `PC_up` out 1: increment program counter.
- `IR_ld` out 1: load instruction register.
- `D_addr` out 8: data-memory address.
- `D_wr` out 1: data-memory write enable.
- `RF_s` out 1: register-file write-data select; 1 = data memory, 0 = ALU.
- `RF_W_addr` out 4: register-file write address.
- `RF_W_en` out 1: register-file write enable.
- `RF_Ra_addr` out 4: register-file read port A address.
- `RF_Rb_addr` out 4: register-file read port B address.
- `ALU_s0` out 3: ALU function; 000 pass A, 001 add, 010 subtract.
- `state_out` out 4: current state encoding, for display/debug.

## Operation
- Opcodes:
  - NOOP 0000.
  - STORE 0001: Ra=IR[11:8], addr=IR[7:0].
  - LOAD 0010: addr=IR[11:4], W=IR[3:0].
  - ADD 0011 and SUB 0100: Ra=IR[11:8], Rb=IR[7:4], W=IR[3:0].
  - HALT 0101.
  - Any other opcode executes as NOOP.
- States and `state_out` codes: Init 0, FetchA 1, FetchB 2, Decode 3, NoOp 4, LoadA 5, LoadB 6, Store 7, Add 8, Sub 9, Halt 10.
- State transitions:
  - Init → FetchA → FetchB → Decode.
  - Decode → the execute state for the opcode.
  - LoadA → LoadB.
  - NoOp, LoadB, Store, Add and Sub → FetchA.
  - Halt → Halt until reset.
- Outputs are Moore, decoded from the state only.
- Default output value is 0 in every state unless listed below.
- Per-state outputs:
  - Init: `PC_clr`=1.
  - FetchA: none; the instruction memory registers the PC address.
  - FetchB: `IR_ld`=1, `PC_up`=1.
  - Decode: none.
  - LoadA: `D_addr`=IR[11:4], `RF_s`=1, `RF_W_addr`=IR[3:0].
  - LoadB: same as LoadA, plus `RF_W_en`=1.
  - Store: `D_addr`=IR[7:0], `RF_Ra_addr`=IR[11:8], `D_wr`=1.
  - Add: `RF_Ra_addr`=IR[11:8], `RF_Rb_addr`=IR[7:4], `RF_W_addr`=IR[3:0], `RF_W_en`=1, `RF_s`=0, `ALU_s0`=001.
  - Sub: same as Add, but `ALU_s0`=010.
- `IR` is sampled only in Decode and the execute states; it is stable there because `IR_ld` is 0.

## Timing
- While `reset_n`=0, and immediately on its assertion (asynchronous):
  - state = Init, `state_out`=0.
  - `PC_clr`=1; every other output is 0.
- First rising edge after `reset_n` deasserts: Init → FetchA. PC is 0 from that edge on.
- FetchA ends with the memory registering the address. FetchB ends with IR ← M[PC] and PC ← PC+1 on the same edge.
- Cycles per instruction, including fetch and decode:
  - NOOP, STORE, ADD, SUB: 4.
  - LOAD: 5 (one extra cycle for data-memory read latency).
  - HALT: 3 cycles to reach Halt, then it stays there.
- `reset_n` asserted mid-instruction aborts immediately to Init. No partial write is held: `D_wr` and `RF_W_en` drop to 0 asynchronously.
- Halt is absorbing. `PC_up`, `IR_ld`, `D_wr` and `RF_W_en` stay 0 there.
- The state register is the only sequential element; there are no output registers and no extra latency.

## Structure
- Package `control_pkg`:
  - `state_t` enum, 4-bit, with the encodings above.
  - Opcode constants `OP_NOOP` … `OP_HALT`.
  - ALU select constants `ALU_PASS`, `ALU_ADD`, `ALU_SUB`.
- Single module; the next-state and output decode live in separate combinational blocks.
- An optional combinational sub-module `ir_fields` extracts the opcode, Ra, Rb, W and the two address fields.

## Test plan
- Reset → hold `reset_n`=0 for 3 cycles → `state_out`=0, `PC_clr`=1, all other outputs 0. Release `reset_n` → `state_out` sequence 1,2,3; `IR_ld`=`PC_up`=1 only in state 2.
- IR=16'h2A53 (LOAD) → LoadA then LoadB.
  - Both states: `D_addr`=8'hA5, `RF_W_addr`=3, `RF_s`=1.
  - `RF_W_en`=1 in LoadB only.
  - Next state FetchA; 5 cycles per instruction.
- IR=16'h1712 (STORE) → Store: `D_addr`=8'h12, `RF_Ra_addr`=7, `D_wr`=1 for exactly 1 cycle.
- IR=16'h3123 (ADD), then IR=16'h4456 (SUB):
  - ADD: `RF_Ra_addr`=1, `RF_Rb_addr`=2, `RF_W_addr`=3, `ALU_s0`=001, `RF_W_en`=1.
  - SUB: `RF_Ra_addr`=4, `RF_Rb_addr`=5, `RF_W_addr`=6, `ALU_s0`=010.
- IR=16'hF000 (unknown opcode) → NoOp (`state_out`=4). IR=16'h5000 (HALT) → `state_out`=10 held for 20 cycles with `PC_up`=0.
- `reset_n` pulsed low mid-cycle during Store → `D_wr` falls immediately, `state_out`=0, `PC_clr`=1 before the next clock edge.

Source files
------------

// File: rtl/control_fsm_pkg.sv
// control_fsm shared types: state encoding, opcodes, ALU selects.
// Imported by the controller and its IR field decoder.
package control_pkg;

    // Values are also the debug/display codes driven on state_out.
    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_FETCH_A = 4'd1,
        S_FETCH_B = 4'd2,
        S_DECODE  = 4'd3,
        S_NOOP    = 4'd4,
        S_LOAD_A  = 4'd5,
        S_LOAD_B  = 4'd6,
        S_STORE   = 4'd7,
        S_ADD     = 4'd8,
        S_SUB     = 4'd9,
        S_HALT    = 4'd10
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/control_fsm_if.sv
// Controller <-> fetch unit / datapath bundle.
// master: controller (drives controls, reads IR); slave: datapath side.
interface control_fsm_if;
    logic [15:0] IR;
    logic        PC_clr;
    logic        PC_up;
    logic        IR_ld;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic [3:0]  state_out;

    modport master (
        input  IR,
        output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s,
        output RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr,
        output ALU_s0, state_out
    );

    modport slave (
        output IR,
        input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s,
        input  RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr,
        input  ALU_s0, state_out
    );
endinterface

// File: rtl/control_fsm_ir_fields.sv
// Combinational instruction field extraction.
// In: ir[15:0]. Out: op, ra, rb, w, ld_addr (LOAD), st_addr (STORE).
module ir_fields (
    input  logic [15:0] ir,
    output logic [3:0]  op,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [3:0]  w,
    output logic [7:0]  ld_addr,
    output logic [7:0]  st_addr
);
    assign op      = ir[15:12];
    assign ra      = ir[11:8];
    assign rb      = ir[7:4];
    assign w       = ir[3:0];
    assign ld_addr = ir[11:4];
    assign st_addr = ir[7:0];
endmodule

// File: rtl/control_fsm.sv
// Processor controller: fetch/decode/execute sequencer, Moore outputs.
// Ports: clk, reset_n (async, active low), bus (control_fsm_if.master).
module control_fsm
    import control_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    control_fsm_if.master bus
);
    state_t state;
    state_t state_nx;

    logic [3:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] w;
    logic [7:0] ld_addr;
    logic [7:0] st_addr;

    ir_fields u_fields (
        .ir      (bus.IR),
        .op      (op),
        .ra      (ra),
        .rb      (rb),
        .w       (w),
        .ld_addr (ld_addr),
        .st_addr (st_addr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_INIT;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = S_INIT;
        unique case (state)
            S_INIT:    state_nx = S_FETCH_A;
            S_FETCH_A: state_nx = S_FETCH_B;
            S_FETCH_B: state_nx = S_DECODE;
            S_DECODE: begin
                // Unassigned opcodes fall through to NoOp.
                unique case (op)
                    OP_STORE: state_nx = S_STORE;
                    OP_LOAD:  state_nx = S_LOAD_A;
                    OP_ADD:   state_nx = S_ADD;
                    OP_SUB:   state_nx = S_SUB;
                    OP_HALT:  state_nx = S_HALT;
                    default:  state_nx = S_NOOP;
                endcase
            end
            S_LOAD_A:  state_nx = S_LOAD_B;
            S_NOOP,
            S_LOAD_B,
            S_STORE,
            S_ADD,
            S_SUB:     state_nx = S_FETCH_A;
            S_HALT:    state_nx = S_HALT;
            default:   state_nx = S_INIT;
        endcase
    end

    always_comb begin
        bus.PC_clr     = 1'b0;
        bus.PC_up      = 1'b0;
        bus.IR_ld      = 1'b0;
        bus.D_addr     = 8'h00;
        bus.D_wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_addr  = 4'h0;
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_addr = 4'h0;
        bus.RF_Rb_addr = 4'h0;
        bus.ALU_s0     = ALU_PASS;
        bus.state_out  = state;
        unique case (state)
            S_INIT: bus.PC_clr = 1'b1;
            S_FETCH_B: begin
                bus.IR_ld = 1'b1;
                bus.PC_up = 1'b1;
            end
            S_LOAD_A, S_LOAD_B: begin
                bus.D_addr    = ld_addr;
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = w;
                // Write only once read data has had a cycle to settle.
                bus.RF_W_en   = (state == S_LOAD_B);
            end
            S_STORE: begin
                bus.D_addr     = st_addr;
                bus.RF_Ra_addr = ra;
                bus.D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                bus.RF_Ra_addr = ra;
                bus.RF_Rb_addr = rb;
                bus.RF_W_addr  = w;
                bus.RF_W_en    = 1'b1;
                bus.ALU_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_fsm.sv
// Testbench for control_fsm: instruction-level reference model,
// directed scenarios plus randomized instruction streams.
module tb_control_fsm;
    typedef struct packed {
        logic       pc_clr;
        logic       pc_up;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
        logic [3:0] st;
    } out_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] next_instr = 16'h0000;
    logic [15:0] ir_q;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    control_fsm_if bus ();

    // Stand-in for the fetch unit: IR register loaded on IR_ld.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)       ir_q <= 16'h0000;
        else if (bus.IR_ld) ir_q <= next_instr;
    end
    assign bus.IR = ir_q;

    control_fsm dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    function automatic out_t sample();
        out_t o;
        o.pc_clr = bus.PC_clr;
        o.pc_up  = bus.PC_up;
        o.ir_ld  = bus.IR_ld;
        o.d_addr = bus.D_addr;
        o.d_wr   = bus.D_wr;
        o.rf_s   = bus.RF_s;
        o.w_addr = bus.RF_W_addr;
        o.w_en   = bus.RF_W_en;
        o.ra     = bus.RF_Ra_addr;
        o.rb     = bus.RF_Rb_addr;
        o.alu    = bus.ALU_s0;
        o.st     = bus.state_out;
        return o;
    endfunction

    function automatic out_t idle_out(input int code);
        out_t o;
        o = '0;
        o.st = code[3:0];
        o.pc_clr = (code == 0);
        return o;
    endfunction

    // Cycles an instruction spends from FetchA until the next FetchA
    // (for HALT: up to and including the first Halt cycle).
    function automatic int n_cycles(input logic [15:0] ins);
        return (ins[15:12] == 4'd2) ? 5 : 4;
    endfunction

    // Expected outputs in cycle k of an instruction, from the ISA rules.
    function automatic out_t expect_cycle(input logic [15:0] ins,
                                          input int k);
        out_t o;
        int   op;
        op = int'(ins[15:12]);
        if (k < 3) begin
            o = idle_out(k + 1);
            if (k == 1) begin
                o.ir_ld = 1'b1;
                o.pc_up = 1'b1;
            end
            return o;
        end
        case (op)
            1: begin
                o = idle_out(7);
                o.d_addr = ins[7:0];
                o.ra = ins[11:8];
                o.d_wr = 1'b1;
            end
            2: begin
                o = idle_out(k == 3 ? 5 : 6);
                o.d_addr = ins[11:4];
                o.rf_s = 1'b1;
                o.w_addr = ins[3:0];
                o.w_en = (k == 4);
            end
            3, 4: begin
                o = idle_out(op == 3 ? 8 : 9);
                o.ra = ins[11:8];
                o.rb = ins[7:4];
                o.w_addr = ins[3:0];
                o.w_en = 1'b1;
                o.alu = (op == 3) ? 3'd1 : 3'd2;
            end
            5: o = idle_out(10);
            default: o = idle_out(4);
        endcase
        return o;
    endfunction

    // Runs one instruction starting at a FetchA negedge, checking
    // every cycle; returns at the negedge following its last cycle.
    task automatic exec_instr(input logic [15:0] ins, input string tag);
        out_t g;
        out_t e;
        next_instr = ins;
        for (int k = 0; k < n_cycles(ins); k++) begin
            g = sample();
            e = expect_cycle(ins, k);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s ins=%h cyc=%0d got=%h exp=%h",
                         tag, ins, k, g, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        out_t g;
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            g = sample();
            checks++;
            if (g !== idle_out(0)) begin
                errors++;
                $display("FAIL reset got=%h exp=%h", g, idle_out(0));
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        exec_instr(16'h2A53, "load");
    endtask

    task automatic test_store();
        exec_instr(16'h1712, "store");
    endtask

    task automatic test_add_sub();
        exec_instr(16'h3123, "add");
        exec_instr(16'h4456, "sub");
    endtask

    task automatic test_unknown();
        exec_instr(16'hF000, "unknown");
        exec_instr(16'h0000, "noop");
    endtask

    task automatic test_random();
        logic [15:0] ins;
        int op;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 14);
            if (op >= 5) op++;
            ins = {op[3:0], 12'($urandom_range(0, 4095))};
            exec_instr(ins, "random");
        end
    endtask

    task automatic test_store_abort();
        out_t g;
        next_instr = 16'h1712;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.D_wr !== 1'b1 || bus.state_out !== 4'd7) begin
            errors++;
            $display("FAIL abort_pre got d_wr=%b st=%0d exp d_wr=1 st=7",
                     bus.D_wr, bus.state_out);
        end
        #2 reset_n = 1'b0;
        #1;
        g = sample();
        checks++;
        if (g !== idle_out(0)) begin
            errors++;
            $display("FAIL abort got=%h exp=%h", g, idle_out(0));
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_halt();
        out_t g;
        exec_instr(16'h5000, "halt_entry");
        repeat (20) begin
            g = sample();
            checks++;
            if (g !== idle_out(10)) begin
                errors++;
                $display("FAIL halt_hold got=%h exp=%h", g, idle_out(10));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_add_sub();
        test_unknown();
        test_random();
        test_store_abort();
        test_load();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
